// File: rtl/fifo_rr_drain_arbiter.sv
// rtl/fifo_rr_drain_arbiter.sv - round-robin burst drain of NUM_PORTS registered-dout fifos onto one valid/ready sink
module fifo_rr_drain_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int data_width = 8,
    parameter int MAX_BURST  = 4,
    parameter int src_width  = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            port_mask,
    input  logic [NUM_PORTS-1:0]            fifo_empty,
    input  logic [NUM_PORTS*data_width-1:0] fifo_dout,
    output logic [NUM_PORTS-1:0]            fifo_rd_en,
    output logic [data_width-1:0]           out_data,
    output logic [src_width-1:0]            out_src,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, READ, LOAD, SEND} state_t;

    state_t               state;
    logic [src_width-1:0] grant;
    logic [src_width-1:0] last_grant;
    logic [src_width-1:0] next_grant;
    logic [CNT_W-1:0]     burst_cnt;
    logic [NUM_PORTS-1:0] eligible;
    logic                 any_eligible;

    function automatic logic [src_width-1:0] wrap_idx(input int i);
        return src_width'(i % NUM_PORTS);
    endfunction

    assign eligible = ~fifo_empty & port_mask;

    // Scan from the farthest offset down so the nearest eligible port after last_grant wins.
    always_comb begin
        next_grant   = last_grant;
        any_eligible = 1'b0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            if (eligible[wrap_idx(int'(last_grant) + k)]) begin
                next_grant   = wrap_idx(int'(last_grant) + k);
                any_eligible = 1'b1;
            end
        end
    end

    // Strobe is gated by rst so a reset landing in READ never pops a word.
    always_comb begin
        fifo_rd_en = '0;
        if (state == READ && !rst) begin
            fifo_rd_en[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= src_width'(NUM_PORTS - 1);
            burst_cnt  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_eligible) begin
                        grant <= next_grant;
                        state <= READ;
                    end
                end
                READ: begin
                    state <= LOAD;
                end
                LOAD: begin
                    out_data  <= fifo_dout[int'(grant)*data_width +: data_width];
                    out_src   <= grant;
                    out_valid <= 1'b1;
                    burst_cnt <= burst_cnt + CNT_W'(1);
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (int'(burst_cnt) < MAX_BURST && !fifo_empty[grant]) begin
                            state <= READ;
                        end else begin
                            last_grant <= grant;
                            burst_cnt  <= '0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// tb/tb_fifo_rr_drain_arbiter.sv - scoreboard bench for fifo_rr_drain_arbiter with modelled registered-dout fifos
module tb_fifo_rr_drain_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int SW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NP-1:0]    port_mask = '1;
    logic [NP-1:0]    fifo_empty = '1;
    logic [NP*DW-1:0] fifo_dout;
    logic [NP-1:0]    fifo_rd_en;
    logic [DW-1:0]    out_data;
    logic [SW-1:0]    out_src;
    logic             out_valid;
    logic             out_ready = 1'b0;

    logic [DW-1:0]    dout_r [NP];
    logic [DW-1:0]    fq [NP][$];
    logic [SW+DW-1:0] sb [$];
    int               rd_count [NP] = '{default: 0};
    logic [NP-1:0]    forbid = '0;
    logic             hold_prev = 1'b0;
    logic [SW+DW-1:0] prev_word = '0;
    int               n_checks = 0;
    int               n_fail = 0;

    fifo_rr_drain_arbiter #(
        .NUM_PORTS (NP),
        .data_width(DW),
        .MAX_BURST (MB),
        .src_width (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .port_mask (port_mask),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always_comb begin
        fifo_dout = '0;
        for (int i = 0; i < NP; i++) fifo_dout[i*DW +: DW] = dout_r[i];
    end

    task automatic check(input logic ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        check(act == exp, name, act, exp);
    endtask

    // Fifo models: dout registered on rd_en, empty flag registered after the pop.
    always @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (fifo_rd_en[i]) begin
                check(fq[i].size() != 0, "rd_en_on_empty_fifo", i, -1);
                if (fq[i].size() != 0) dout_r[i] <= fq[i].pop_front();
            end
            fifo_empty[i] <= (fq[i].size() == 0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check($onehot0(fifo_rd_en), "rd_en_onehot", int'(fifo_rd_en), 0);
            check_eq("rd_en_masked_port", int'(fifo_rd_en & forbid), 0);
            for (int i = 0; i < NP; i++) if (fifo_rd_en[i]) rd_count[i]++;
            if (hold_prev && out_valid) check_eq("held_word", int'({out_src, out_data}), int'(prev_word));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check(1'b0, "unexpected_word", int'({out_src, out_data}), 0);
                else check_eq("out_word", int'({out_src, out_data}), int'(sb.pop_front()));
            end
            hold_prev <= out_valid && !out_ready;
            prev_word <= {out_src, out_data};
        end else begin
            hold_prev <= 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_reset;
        rst       = 1'b1;
        out_ready = 1'b0;
        port_mask = '1;
        forbid    = '0;
        for (int i = 0; i < NP; i++) fq[i].delete();
        tick();
    endtask

    task automatic release_rst;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input int p, input logic [DW-1:0] d);
        fq[p].push_back(d);
    endtask

    task automatic expect_word(input logic [SW-1:0] p, input logic [DW-1:0] d);
        sb.push_back({p, d});
    endtask

    task automatic wait_valid(input int budget, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        check(found, name, 0, 1);
    endtask

    task automatic wait_drain(input int budget, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                found = 1'b1;
                break;
            end
        end
        check(found, name, sb.size(), 0);
    endtask

    initial begin
        int base [NP];

        // Reset state and quiet idle
        begin_reset();
        release_rst();
        @(negedge clk);
        check_eq("reset_out_valid", int'(out_valid), 0);
        check_eq("reset_out_data", int'(out_data), 0);
        check_eq("reset_out_src", int'(out_src), 0);
        repeat (20) begin
            @(negedge clk);
            check_eq("idle_quiet", int'({fifo_rd_en, out_valid}), 0);
        end

        // Single word latency
        begin_reset();
        load(2, 8'hA5);
        expect_word(2, 8'hA5);
        out_ready = 1'b1;
        release_rst();
        @(negedge clk);
        check_eq("t2_c0_rd_en", int'(fifo_rd_en), 0);
        @(negedge clk);
        check_eq("t2_c1_rd_en", int'(fifo_rd_en), 4'b0100);
        @(negedge clk);
        check_eq("t2_c2_valid", int'(out_valid), 0);
        @(negedge clk);
        check_eq("t2_c3_valid", int'(out_valid), 1);
        wait_drain(20, "t2_drain");

        // Burst limit and rotation between ports 0 and 3
        begin_reset();
        for (int k = 0; k < 6; k++) begin
            load(0, 8'h10 + DW'(k));
            load(3, 8'h30 + DW'(k));
        end
        for (int k = 0; k < 4; k++) expect_word(0, 8'h10 + DW'(k));
        for (int k = 0; k < 4; k++) expect_word(3, 8'h30 + DW'(k));
        for (int k = 4; k < 6; k++) expect_word(0, 8'h10 + DW'(k));
        for (int k = 4; k < 6; k++) expect_word(3, 8'h30 + DW'(k));
        for (int i = 0; i < NP; i++) base[i] = rd_count[i];
        out_ready = 1'b1;
        release_rst();
        wait_drain(200, "t3_drain");
        check_eq("t3_rd_count_p0", rd_count[0] - base[0], 6);
        check_eq("t3_rd_count_p3", rd_count[3] - base[3], 6);

        // Back-pressure on port 1
        begin_reset();
        load(1, 8'h21);
        load(1, 8'h22);
        expect_word(1, 8'h21);
        expect_word(1, 8'h22);
        base[1] = rd_count[1];
        release_rst();
        wait_valid(10, "t4_first_valid");
        repeat (10) begin
            @(negedge clk);
            check(out_valid && out_data == 8'h21, "t4_stall_hold", int'({out_valid, out_data}), 'h121);
        end
        check_eq("t4_no_extra_rd", rd_count[1] - base[1], 1);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("t4_hs_valid", int'(out_valid), 1);
        repeat (2) begin
            @(negedge clk);
            check_eq("t4_gap_valid", int'(out_valid), 0);
        end
        @(negedge clk);
        check_eq("t4_second_valid_k3", int'(out_valid), 1);
        wait_drain(20, "t4_drain");
        check_eq("t4_rd_count_p1", rd_count[1] - base[1], 2);

        // Port mask excludes ports 0 and 2
        begin_reset();
        port_mask = 4'b1010;
        forbid    = 4'b0101;
        for (int i = 0; i < NP; i++) begin
            load(i, 8'h40 + DW'(16*i));
            load(i, 8'h41 + DW'(16*i));
        end
        expect_word(1, 8'h50);
        expect_word(1, 8'h51);
        expect_word(3, 8'h70);
        expect_word(3, 8'h71);
        for (int i = 0; i < NP; i++) base[i] = rd_count[i];
        out_ready = 1'b1;
        release_rst();
        wait_drain(100, "t5_drain");
        repeat (20) tick();
        check_eq("t5_rd_count_p0", rd_count[0] - base[0], 0);
        check_eq("t5_rd_count_p1", rd_count[1] - base[1], 2);
        check_eq("t5_rd_count_p2", rd_count[2] - base[2], 0);
        check_eq("t5_rd_count_p3", rd_count[3] - base[3], 2);
        forbid = '0;

        // Reset in READ, then in SEND
        begin_reset();
        load(0, 8'h01);
        for (int k = 1; k <= 3; k++) load(1, 8'h10 + DW'(k));
        for (int i = 0; i < NP; i++) base[i] = rd_count[i];
        release_rst();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_rd_en_rst_in_read", int'(fifo_rd_en), 0);
        tick();
        @(negedge clk);
        check_eq("t6_valid_after_rst_read", int'(out_valid), 0);
        check_eq("t6_no_pop_p0", rd_count[0] - base[0], 0);
        tick();
        rst = 1'b0;
        wait_valid(10, "t6_valid");
        check_eq("t6_restart_port0", int'({out_src, out_data}), 'h001);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_rd_en_rst_in_send", int'(fifo_rd_en), 0);
        tick();
        @(negedge clk);
        check_eq("t6_word_discarded", int'(out_valid), 0);
        for (int k = 1; k <= 3; k++) expect_word(1, 8'h10 + DW'(k));
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        wait_drain(60, "t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
